pe_operand_stage: RTL and testbench
===================================

Name: pe_operand_stage

Overview:
- Registered operand staging slice that sits directly upstream of the PE compute unit.
- Accepts routed data words, a predicate bit and a 9-bit op code under valid/ready.
- Per operand, selects the routed input, a configured constant, the last accepted value (hold) or the fed-back compute result (accumulate).
- Presents the staged operands to the compute unit's op_a/op_b/op_d_p/op_code inputs through a 2-entry skid buffer, giving full throughput with registered input ready.

Parameters:
- DataWidth, 16, width of data operands and constants.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-high; clears all state.
- flush  in  1  synchronous clear of both buffer entries; hold registers unaffected.
- cfg_mode_a  in  2  op_a source: 0 INPUT, 1 CONST, 2 HOLD, 3 ACCUM.
- cfg_mode_b  in  2  op_b source: 0 INPUT, 1 CONST, 2 HOLD, 3 INPUT (reserved, same as 0).
- cfg_mode_d  in  2  op_d_p source: 0 INPUT, 1 CONST, 2 HOLD, 3 INPUT (reserved, same as 0).
- cfg_const_a  in  DataWidth  constant for op_a.
- cfg_const_b  in  DataWidth  constant for op_b.
- cfg_const_d  in  1  constant for op_d_p.
- in_valid  in  1  upstream word valid.
- in_ready  out  1  stage can accept.
- in_data0  in  DataWidth  routed operand A.
- in_data1  in  DataWidth  routed operand B.
- in_bit0  in  1  routed predicate.
- in_op_code  in  9  op code travelling with the operands.
- acc_in  in  DataWidth  compute-unit result fed back for ACCUM.
- out_valid  out  1  staged operand set valid.
- out_ready  in  1  downstream consumes the set.
- op_a  out  DataWidth  staged operand A.
- op_b  out  DataWidth  staged operand B.
- op_d_p  out  1  staged predicate.
- op_code  out  9  staged op code.

Behaviour:
- State:
  - main entry {valid, a, b, d, code} drives the outputs directly.
  - skid entry {valid, a, b, d, code}.
  - hold regs hold_a, hold_b, hold_d.
- Reset values: all of the above are 0; out_valid=0; in_ready=1.
- Accept: accept = in_valid & in_ready. Operand values are resolved in the accept cycle from cfg_* and acc_in as sampled that cycle.
  - INPUT: in_data0 / in_data1 / in_bit0.
  - CONST: cfg_const_*.
  - HOLD: the hold reg.
  - ACCUM: acc_in.
- Hold update: on each accept, hold_* <= resolved value. HOLD therefore repeats the last accepted operand, and it is 0 after reset.
- in_ready = ~skid.valid, from a register only; no combinational path from out_ready.
- Latency: an accepted set appears on the outputs the next cycle when main is free.
- Per-cycle update, with pop = out_valid & out_ready:
  - main empty or pop, and skid empty: main <= accepted set if accept, else main.valid <= 0.
  - pop and skid full: main <= skid, skid.valid <= 0. No accept is possible in this case, because in_ready=0.
  - main full, no pop, accept: skid <= accepted set.
- Ordering is strictly FIFO. A set is never dropped or duplicated.
- Maximum occupancy is 2. in_ready falls the cycle after the skid fills.
- Sustained in_valid & out_ready gives 1 set per cycle.
- out_valid = main.valid.
- Output stability: op_* and op_code are stable while out_valid & ~out_ready.
- flush: both valid bits are cleared next cycle, and flush wins over a simultaneous accept or pop. The accepted set is discarded, but hold_* still updates.
- rst asserted mid-transfer: state clears immediately (asynchronous); outputs read 0 and out_valid=0 until the first accept after release.
- Config changes: cfg_* changes only affect sets accepted afterwards. Buffered sets keep their resolved values.
- ACCUM uses acc_in as-is; no width extension or saturation is applied.

Test Plan:
- Reset, then in_valid=1 with data0=0x0003, data1=0x0005, bit0=1, op_code=0x000, out_ready=1, all modes INPUT -> next cycle out_valid=1, op_a=3, op_b=5, op_d_p=1, op_code=0; one set per cycle thereafter.
- Backpressure: out_ready=0 while 3 sets (0x11,0x22,0x33) are offered -> main=0x11, skid=0x22, in_ready=0 the cycle after the skid fills, 0x33 held upstream. Then raise out_ready -> outputs 0x11, 0x22, 0x33 on consecutive cycles.
- cfg_mode_b=CONST with cfg_const_b=0x00FF and in_data1=0x1234 -> op_b=0x00FF. Then cfg_mode_a=HOLD after accepting a=0x0042 -> subsequent sets show op_a=0x0042 regardless of in_data0.
- cfg_mode_a=ACCUM with acc_in=0x0010 in the accept cycle -> op_a=0x0010 for that set, even if acc_in changes while the set stalls.
- With both entries full, assert flush together with in_valid -> out_valid=0 and in_ready=1 next cycle, and nothing from that cycle is emitted.
- Assert rst asynchronously between clock edges with 2 sets buffered -> out_valid and op_* read 0 immediately, hold regs read 0, and the next accept shows new values only.

Source files
------------

// File: rtl/pe_operand_stage.sv
// pe_operand_stage: resolves PE operands from routed input, constants, hold or accumulator
// and presents them to the compute unit through a 2-entry skid buffer.
module pe_operand_stage #(
    parameter int DataWidth = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic [1:0]           cfg_mode_a,
    input  logic [1:0]           cfg_mode_b,
    input  logic [1:0]           cfg_mode_d,
    input  logic [DataWidth-1:0] cfg_const_a,
    input  logic [DataWidth-1:0] cfg_const_b,
    input  logic                 cfg_const_d,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DataWidth-1:0] in_data0,
    input  logic [DataWidth-1:0] in_data1,
    input  logic                 in_bit0,
    input  logic [8:0]           in_op_code,
    input  logic [DataWidth-1:0] acc_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DataWidth-1:0] op_a,
    output logic [DataWidth-1:0] op_b,
    output logic                 op_d_p,
    output logic [8:0]           op_code
);
    logic                 m_valid, s_valid;
    logic [DataWidth-1:0] m_a, m_b, s_a, s_b, hold_a, hold_b;
    logic                 m_d, s_d, hold_d;
    logic [8:0]           m_code, s_code;
    logic [DataWidth-1:0] res_a, res_b;
    logic                 res_d, accept, pop;
    always_comb begin
        res_a = cfg_mode_a == 2'd0 ? in_data0 :
                cfg_mode_a == 2'd1 ? cfg_const_a :
                cfg_mode_a == 2'd2 ? hold_a : acc_in;
        res_b = cfg_mode_b == 2'd1 ? cfg_const_b :
                cfg_mode_b == 2'd2 ? hold_b : in_data1;
        res_d = cfg_mode_d == 2'd1 ? cfg_const_d :
                cfg_mode_d == 2'd2 ? hold_d : in_bit0;
    end
    assign in_ready  = ~s_valid;
    assign accept    = in_valid & ~s_valid;
    assign pop       = m_valid & out_ready;
    assign out_valid = m_valid;
    assign op_a      = m_a;
    assign op_b      = m_b;
    assign op_d_p    = m_d;
    assign op_code   = m_code;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {m_valid, m_a, m_b, m_d, m_code} <= '0;
            {s_valid, s_a, s_b, s_d, s_code} <= '0;
            {hold_a, hold_b, hold_d}         <= '0;
        end else begin
            if (accept) {hold_a, hold_b, hold_d} <= {res_a, res_b, res_d};
            // flush discards everything buffered, including a set accepted this cycle
            if (flush) begin
                m_valid <= 1'b0;
                s_valid <= 1'b0;
            end else if (!m_valid || pop) begin
                if (s_valid) begin
                    {m_a, m_b, m_d, m_code} <= {s_a, s_b, s_d, s_code};
                    s_valid <= 1'b0;
                end else if (accept) begin
                    {m_a, m_b, m_d, m_code} <= {res_a, res_b, res_d, in_op_code};
                end
                m_valid <= s_valid | accept;
            end else if (accept) begin
                {s_a, s_b, s_d, s_code} <= {res_a, res_b, res_d, in_op_code};
                s_valid <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_pe_operand_stage.sv
// tb_pe_operand_stage: directed and randomized checks against a 2-deep FIFO reference model.
module tb_pe_operand_stage;
    logic        clk = 1'b0, rst = 1'b1, flush = 1'b0;
    logic [1:0]  cfg_mode_a = '0, cfg_mode_b = '0, cfg_mode_d = '0;
    logic [15:0] cfg_const_a = '0, cfg_const_b = '0;
    logic        cfg_const_d = 1'b0;
    logic        in_valid = 1'b0, in_ready;
    logic [15:0] in_data0 = '0, in_data1 = '0, acc_in = '0;
    logic        in_bit0 = 1'b0;
    logic [8:0]  in_op_code = '0;
    logic        out_valid, out_ready = 1'b0;
    logic [15:0] op_a, op_b;
    logic        op_d_p;
    logic [8:0]  op_code;

    pe_operand_stage #(.DataWidth(16)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .cfg_mode_a(cfg_mode_a), .cfg_mode_b(cfg_mode_b), .cfg_mode_d(cfg_mode_d),
        .cfg_const_a(cfg_const_a), .cfg_const_b(cfg_const_b), .cfg_const_d(cfg_const_d),
        .in_valid(in_valid), .in_ready(in_ready), .in_data0(in_data0), .in_data1(in_data1),
        .in_bit0(in_bit0), .in_op_code(in_op_code), .acc_in(acc_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .op_a(op_a), .op_b(op_b), .op_d_p(op_d_p), .op_code(op_code)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic        d;
        logic [8:0]  code;
    } set_t;

    set_t        q[$];
    logic [15:0] ha = '0, hb = '0;
    logic        hd = 1'b0;
    int          n_checks = 0, n_fail = 0;
    bit          last_acc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic compare();
        check("out_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
        check("in_ready", {31'd0, in_ready}, {31'd0, q.size() < 2});
        if (q.size() > 0) begin
            check("op_a", {16'd0, op_a}, {16'd0, q[0].a});
            check("op_b", {16'd0, op_b}, {16'd0, q[0].b});
            check("op_d_p", {31'd0, op_d_p}, {31'd0, q[0].d});
            check("op_code", {23'd0, op_code}, {23'd0, q[0].code});
        end
    endtask

    // Inputs are set after a falling edge; this advances one clock and checks at the next falling edge.
    task automatic tick();
        set_t s;
        bit   acc, pop;
        acc = in_valid && q.size() < 2;
        pop = out_ready && q.size() > 0;
        case (cfg_mode_a)
            2'd0: s.a = in_data0;
            2'd1: s.a = cfg_const_a;
            2'd2: s.a = ha;
            default: s.a = acc_in;
        endcase
        s.b = cfg_mode_b == 2'd1 ? cfg_const_b : cfg_mode_b == 2'd2 ? hb : in_data1;
        s.d = cfg_mode_d == 2'd1 ? cfg_const_d : cfg_mode_d == 2'd2 ? hd : in_bit0;
        s.code = in_op_code;
        @(posedge clk);
        if (acc) begin
            ha = s.a;
            hb = s.b;
            hd = s.d;
        end
        if (flush) q.delete();
        else begin
            if (pop) void'(q.pop_front());
            if (acc) q.push_back(s);
        end
        last_acc = acc;
        @(negedge clk);
        compare();
    endtask

    task automatic async_reset();
        #2 rst = 1'b1;
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_op_a", {16'd0, op_a}, 32'd0);
        check("rst_op_b", {16'd0, op_b}, 32'd0);
        check("rst_op_d_p", {31'd0, op_d_p}, 32'd0);
        check("rst_op_code", {23'd0, op_code}, 32'd0);
        q.delete();
        ha = '0;
        hb = '0;
        hd = 1'b0;
        #1 rst = 1'b0;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        flush     = 1'b0;
        repeat (3) tick();
    endtask

    logic [15:0] vals[3];
    int          idx;

    initial begin
        vals = '{16'h0011, 16'h0022, 16'h0033};
        repeat (2) @(negedge clk);
        async_reset();

        // basic pass-through, then one set per cycle
        in_valid = 1'b1; out_ready = 1'b1;
        in_data0 = 16'h0003; in_data1 = 16'h0005; in_bit0 = 1'b1; in_op_code = 9'h000;
        tick();
        check("first_op_a", {16'd0, op_a}, 32'h3);
        for (int i = 0; i < 4; i++) begin
            in_data0 = 16'h0100 + 16'(i); in_data1 = 16'h0200 + 16'(i);
            in_bit0 = i[0]; in_op_code = 9'(i * 37);
            tick();
        end
        drain();

        // backpressure
        idx = 0; out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = idx < 3;
            if (idx < 3) begin in_data0 = vals[idx]; in_data1 = vals[idx]; end
            tick();
            if (last_acc) idx++;
        end
        check("bp_accepted", idx, 2);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = idx < 3;
            if (idx < 3) begin in_data0 = vals[idx]; in_data1 = vals[idx]; end
            tick();
            if (last_acc) idx++;
        end
        check("bp_all_accepted", idx, 3);
        drain();

        // CONST then HOLD
        in_valid = 1'b1;
        cfg_mode_b = 2'd1; cfg_const_b = 16'h00FF; in_data1 = 16'h1234;
        tick();
        check("const_b", {16'd0, op_b}, 32'h00FF);
        in_data0 = 16'h0042; tick();
        cfg_mode_a = 2'd2;
        for (int i = 0; i < 3; i++) begin in_data0 = 16'($urandom); tick(); end
        check("hold_a", {16'd0, op_a}, 32'h0042);
        drain();

        // ACCUM captured at accept, stable while stalled
        cfg_mode_a = 2'd3; acc_in = 16'h0010; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_valid = 1'b0; acc_in = 16'h0099;
        tick(); tick();
        check("accum_a", {16'd0, op_a}, 32'h0010);
        drain();

        // flush with both entries full
        cfg_mode_a = 2'd0; cfg_mode_b = 2'd0; out_ready = 1'b0; in_valid = 1'b1;
        repeat (3) tick();
        flush = 1'b1; in_data0 = 16'hDEAD;
        tick();
        check("flush_valid", {31'd0, out_valid}, 32'd0);
        drain();

        // asynchronous reset with two sets buffered, then HOLD must read zero
        out_ready = 1'b0; in_valid = 1'b1; in_data0 = 16'h7777; in_data1 = 16'h8888; in_bit0 = 1'b1;
        repeat (3) tick();
        async_reset();
        cfg_mode_a = 2'd2; cfg_mode_b = 2'd2; cfg_mode_d = 2'd2; out_ready = 1'b1;
        tick();
        check("post_rst_hold_a", {16'd0, op_a}, 32'd0);
        drain();

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            flush     = ($urandom % 25) == 0;
            if (($urandom % 8) == 0) begin
                cfg_mode_a = 2'($urandom); cfg_mode_b = 2'($urandom); cfg_mode_d = 2'($urandom);
                cfg_const_a = 16'($urandom); cfg_const_b = 16'($urandom); cfg_const_d = 1'($urandom);
            end
            in_data0 = 16'($urandom); in_data1 = 16'($urandom); in_bit0 = 1'($urandom);
            in_op_code = 9'($urandom); acc_in = 16'($urandom);
            tick();
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
